blur_engine: RTL
================

// Module: blur_engine
// PURPOSE
//   Responder end of the main-FSM start/done handshake for the blur step.
//   A one-cycle blur_start pulse makes it stream the whole source frame buffer
//   and apply a horizontal 3-tap [1 2 1]/4 blur per RGB444 channel.
//   Results go to a separate destination buffer, then blur_done pulses.
//   It sits between the source frame BRAM and the transformed-image BRAM.
// PARAMETERS
//   WIDTH   640  pixels per row (>=2)
//   HEIGHT  480  rows per frame (>=1)
//   ADDR_W  19   frame buffer address width; must hold WIDTH*HEIGHT-1
//   RD_LAT  2    source read latency in cycles (rd_en at cycle t -> rd_data valid at t+RD_LAT)
// PORTS
//   clk         in   1       system clock; all logic on posedge
//   rst_n       in   1       asynchronous, active-low reset
//   blur_start  in   1       one-cycle start pulse; sampled only in IDLE
//   blur_done   out  1       one-cycle pulse when the frame is fully written
//   busy        out  1       high in RUN, DRAIN and DONE
//   rd_en       out  1       source read strobe
//   rd_addr     out  ADDR_W  source address, row*WIDTH+col
//   rd_data     in   12      source pixel {R[11:8],G[7:4],B[3:0]}
//   wr_en       out  1       destination write strobe (registered)
//   wr_addr     out  ADDR_W  destination address, row*WIDTH+col
//   wr_data     out  12      blurred pixel
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, all counters 0. blur_done, busy, rd_en
//     and wr_en are 0. rd_addr, wr_addr and wr_data are 0. Reset mid-frame
//     aborts immediately; no write is issued until a new blur_start.
//   FSM:
//     IDLE  -> RUN on blur_start.
//     RUN   -> DRAIN after S = HEIGHT*(WIDTH+1) slots.
//     DRAIN -> DONE after RD_LAT+1 cycles.
//     DONE  -> IDLE after 1 cycle; blur_done=1 only in DONE.
//     blur_start outside IDLE is ignored. It does not queue or restart.
//   RUN issues one slot per cycle, in row-major order. Each row has WIDTH
//     read slots (rd_en=1) followed by one flush slot (rd_en=0) at col=WIDTH.
//   Per-slot tags (valid, flush, col, row) are delayed RD_LAT cycles so they
//     align with rd_data.
//   Window registers L/C hold the previous two returned pixels of the current
//     row. When slot col=k returns:
//       - if k>=1, output pixel x=k-1 with left=L (or C if x=0), centre=C,
//         and right = the new pixel, or C if this is the flush slot;
//       - then shift the window.
//     The flush slot produces x=WIDTH-1 and clears the window for the next row.
//   Per channel: out = (l + 2c + r + 2) >> 2, computed in 6 bits.
//     The maximum is (60+2)>>2 = 15, so the result never overflows 4 bits.
//   Output is registered: wr_en/wr_addr/wr_data are valid the cycle after the
//     aligned data. Exactly WIDTH*HEIGHT writes occur, each address once,
//     in ascending order.
//   Timing: take blur_start sampled at cycle 0.
//     - RUN occupies cycles 1..S; DRAIN occupies S+1..S+RD_LAT+1.
//     - blur_done=1 exactly in cycle S+RD_LAT+2.
//     - The last write is in cycle S+RD_LAT+1.
//   The source is never written and the destination is never read, so there
//     are no read/write hazards.
// TESTING (bench uses WIDTH=8, HEIGHT=2, RD_LAT=2, BRAM models)
//   Uniform 0x5A3 frame, start pulse -> all 16 outputs 0x5A3; blur_done in
//     cycle 22 only; 16 writes to addrs 0..15.
//   Source zero except 0xF00 at (5,1) -> (5,1)=0x800, (4,1)=(6,1)=0x400,
//     all other pixels 0x000.
//   Left edge: 0x00F at (0,0), rest 0 -> (0,0)=0x00B, (1,0)=0x004; row 1
//     unaffected, i.e. no bleed across rows.
//   Right edge: 0x0F0 at (7,0) -> (7,0)=0x0B0, (6,0)=0x040, (0,1)=0x000.
//   blur_start held high for 5 cycles and re-pulsed mid-RUN -> one frame
//     only; 16 writes; a single blur_done pulse.
//   rst_n low at cycle 9 for 2 cycles -> all outputs 0 asynchronously, no
//     further writes, busy=0; a fresh start then completes normally.

Source files
------------

// File: rtl/blur_engine.sv
// Streams a frame from the source buffer, applies a horizontal [1 2 1]/4 blur
// per RGB444 channel and writes the result to the destination buffer.
module blur_engine #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              blur_start,
    output logic              blur_done,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [11:0]       rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(HEIGHT + 1);
    localparam int DW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, next_state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DW-1:0]     drain_cnt;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] wr_cnt;
    logic              last_slot;
    logic              start_ok;

    // Slot tags travel alongside the read so they line up with rd_data.
    logic          tag_v [RD_LAT];
    logic          tag_f [RD_LAT];
    logic [CW-1:0] tag_c [RD_LAT];

    logic          a_v, a_f;
    logic [CW-1:0] a_c;
    logic [11:0]   win_l, win_c;
    logic [11:0]   left_px, right_px, blurred;

    function automatic logic [3:0] tap(input logic [3:0] l, input logic [3:0] c,
                                       input logic [3:0] r);
        logic [5:0] s;
        s = {2'b00, l} + {1'b0, c, 1'b0} + {2'b00, r} + 6'd2;
        return s[5:2];
    endfunction

    assign start_ok  = (state == IDLE) && blur_start;
    assign last_slot = (col == CW'(WIDTH)) && (row == RW'(HEIGHT - 1));
    assign rd_en     = (state == RUN) && (col != CW'(WIDTH));
    assign rd_addr   = rd_addr_q;
    assign busy      = (state != IDLE);
    assign blur_done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (blur_start) next_state = RUN;
            RUN:     if (last_slot) next_state = DRAIN;
            DRAIN:   if (drain_cnt == DW'(RD_LAT)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Slot counters: WIDTH read slots then one flush slot per row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            drain_cnt <= '0;
            rd_addr_q <= '0;
        end else if (start_ok) begin
            col       <= '0;
            row       <= '0;
            drain_cnt <= '0;
            rd_addr_q <= '0;
        end else if (state == RUN) begin
            if (col == CW'(WIDTH)) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col       <= col + CW'(1);
                rd_addr_q <= rd_addr_q + ADDR_W'(1);
            end
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_v[i] <= 1'b0;
                tag_f[i] <= 1'b0;
                tag_c[i] <= '0;
            end
        end else begin
            tag_v[0] <= (state == RUN);
            tag_f[0] <= (col == CW'(WIDTH));
            tag_c[0] <= col;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_f[i] <= tag_f[i-1];
                tag_c[i] <= tag_c[i-1];
            end
        end
    end

    assign a_v = tag_v[RD_LAT-1];
    assign a_f = tag_f[RD_LAT-1];
    assign a_c = tag_c[RD_LAT-1];

    // Pixel x = col-1: left edge replicates centre, flush slot replicates centre on the right.
    always_comb begin
        left_px  = (a_c == CW'(1)) ? win_c : win_l;
        right_px = a_f ? win_c : rd_data;
        blurred  = {tap(left_px[11:8], win_c[11:8], right_px[11:8]),
                    tap(left_px[7:4],  win_c[7:4],  right_px[7:4]),
                    tap(left_px[3:0],  win_c[3:0],  right_px[3:0])};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_cnt  <= '0;
            win_l   <= '0;
            win_c   <= '0;
        end else begin
            wr_en <= a_v && (a_c != '0);
            if (start_ok) begin
                wr_cnt <= '0;
                win_l  <= '0;
                win_c  <= '0;
            end else if (a_v) begin
                if (a_c != '0) begin
                    wr_data <= blurred;
                    wr_addr <= wr_cnt;
                    wr_cnt  <= wr_cnt + ADDR_W'(1);
                end
                if (a_f) begin
                    win_l <= '0;
                    win_c <= '0;
                end else begin
                    win_l <= win_c;
                    win_c <= rd_data;
                end
            end
        end
    end

endmodule
